// File: rtl/mips_harvard_test_monitor.sv
// Loadable instruction ROM and run-control checker for the Harvard MIPS CPU benches.
// Optional macro MONITOR_ACTIVE_HALT_EN adds a falling-edge-of-active halt and the halt_by_active output.
module mips_harvard_test_monitor #(
   parameter int          ROM_DEPTH      = 64,
   parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR      = 32'h00000000,
   parameter int          TIMEOUT_CYCLES = 256,
   localparam int         AW             = $clog2(ROM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_index,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic [31:0]   expected_v0,
   input  logic [31:0]   instr_address,
   output logic [31:0]   instr_readdata,
   input  logic          active,
   input  logic [31:0]   register_v0,
`ifdef MONITOR_ACTIVE_HALT_EN
   output logic          halt_by_active,
`endif
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic [15:0]   cycle_count,
   output logic [31:0]   v0_captured
);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_CHECK, S_PASS, S_FAIL, S_TIMEOUT
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t state, state_next;

   logic [31:0]   rom [ROM_DEPTH];
   logic [31:0]   offset;
   logic [AW-1:0] rd_idx;
   logic          in_range;
   logic          load_ok;
   logic          start_run;
   logic          addr_halt;
   logic          halt;

   // Combinational fetch: the CPU samples the instruction in the same cycle it drives the address.
   assign offset         = instr_address - RESET_VECTOR;
   assign rd_idx         = offset[AW+1:2];
   assign in_range       = (offset[1:0] == 2'b00) && (offset[31:AW+2] == '0);
   assign instr_readdata = in_range ? rom[rd_idx] : 32'h00000000;

   assign load_ok   = load_en && (state != S_RUN) && (state != S_CHECK);
   assign start_run = start && (state != S_RUN) && (state != S_CHECK);
   assign addr_halt = (instr_address == HALT_ADDR);

   always_ff @(posedge clk) begin
      if (load_ok) begin
         rom[load_index] <= load_data;
      end
   end

`ifdef MONITOR_ACTIVE_HALT_EN
   logic active_p1;
   logic act_halt;

   assign act_halt = active_p1 && !active;
   assign halt     = addr_halt || act_halt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_p1      <= 1'b0;
         halt_by_active <= 1'b0;
      end else begin
         active_p1 <= active;
         if (start_run) begin
            halt_by_active <= 1'b0;
         end else if (state == S_RUN && act_halt) begin
            halt_by_active <= 1'b1;
         end
      end
   end
`else
   logic unused_active;

   assign unused_active = active;
   assign halt          = addr_halt;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_RUN;
         S_RUN: begin
            // Halt takes priority over a timeout landing on the same edge.
            if (halt) begin
               state_next = S_CHECK;
            end else if (cycle_count == TO_LAST) begin
               state_next = S_TIMEOUT;
            end
         end
         S_CHECK:   state_next = (v0_captured == expected_v0) ? S_PASS : S_FAIL;
         S_PASS,
         S_FAIL,
         S_TIMEOUT: if (start) state_next = S_RUN;
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cycle_count <= 16'h0000;
         v0_captured <= 32'h00000000;
      end else begin
         state <= state_next;
         if (start_run) begin
            cycle_count <= 16'h0000;
         end else if (state == S_RUN && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'h0001;
         end
         if (state == S_RUN && halt) begin
            v0_captured <= register_v0;
         end
      end
   end

   // Flags decode registered state only.
   assign busy    = (state == S_RUN) || (state == S_CHECK);
   assign done    = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
   assign pass    = (state == S_PASS);
   assign fail    = (state == S_FAIL) || (state == S_TIMEOUT);
   assign timeout = (state == S_TIMEOUT);

endmodule

// File: tb/tb_mips_harvard_test_monitor.sv
// Scoreboard bench for mips_harvard_test_monitor; the bench plays the CPU by driving fetch addresses and $v0.
module tb_mips_harvard_test_monitor;

   localparam int          DEPTH = 64;
   localparam logic [31:0] RV    = 32'hBFC00000;
   localparam int          TO    = 50;
   localparam int          AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_index;
   logic [31:0]   load_data;
   logic          start;
   logic [31:0]   expected_v0;
   logic [31:0]   instr_address;
   logic [31:0]   instr_readdata;
   logic          active;
   logic [31:0]   register_v0;
   logic          busy, done, pass, fail, timeout;
   logic [15:0]   cycle_count;
   logic [31:0]   v0_captured;
`ifdef MONITOR_ACTIVE_HALT_EN
   logic          halt_by_active;
`endif

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        timeout;
      logic [31:0] v0;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] prog [13];

   mips_harvard_test_monitor #(
      .ROM_DEPTH(DEPTH), .RESET_VECTOR(RV), .HALT_ADDR(32'h0), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_index(load_index),
      .load_data(load_data), .start(start), .expected_v0(expected_v0),
      .instr_address(instr_address), .instr_readdata(instr_readdata),
      .active(active), .register_v0(register_v0),
`ifdef MONITOR_ACTIVE_HALT_EN
      .halt_by_active(halt_by_active),
`endif
      .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .cycle_count(cycle_count), .v0_captured(v0_captured)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic load_word(input int idx, input logic [31:0] data);
      @(negedge clk);
      load_en = 1'b1; load_index = AW'(idx); load_data = data;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 13; i++) load_word(i, prog[i]);
   endtask

   task automatic start_run(input logic [31:0] ev0, input exp_t e);
      @(negedge clk);
      expected_v0 = ev0; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Scoreboard pop: compare outcome against the entry pushed at start.
   task automatic wait_done(input int budget, output int waited);
      exp_t e;
      waited = 0;
      while (!done && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("res_pass", {31'd0, pass}, {31'd0, e.pass});
         chk("res_fail", {31'd0, fail}, {31'd0, e.fail});
         chk("res_timeout", {31'd0, timeout}, {31'd0, e.timeout});
         chk("res_v0", v0_captured, e.v0);
      end
   endtask

   // Sequential walk through the 13-word program, then the jr $0 lands on address 0.
   task automatic run_seq(input logic [31:0] ev0, input exp_t e, input bool_corrupt);
      int w;
      start_run(ev0, e);
      for (int k = 0; k < 13; k++) begin
         instr_address = RV + 32'(4 * k);
         if (bool_corrupt && k == 5) begin
            load_en = 1'b1; load_index = AW'(3); load_data = 32'hDEADBEEF;
         end else begin
            load_en = 1'b0;
         end
         #1 chk("fetch", instr_readdata, prog[k]);
         @(negedge clk);
      end
      load_en = 1'b0;
      instr_address = 32'h0;
      wait_done(40, w);
      chk("halt_latency", 32'(w), 32'd2);
      chk("cycles_at_halt", {16'd0, cycle_count}, 32'd14);
      instr_address = RV;
   endtask

   initial begin
      int w;
      prog[0]  = 32'h24020000; prog[1]  = 32'h24030008; prog[2]  = 32'h18600005;
      prog[3]  = 32'h00000000; prog[4]  = 32'h24420010; prog[5]  = 32'h2463FFFF;
      prog[6]  = 32'h1000FFFB; prog[7]  = 32'h00000000; prog[8]  = 32'h00000000;
      prog[9]  = 32'h00000000; prog[10] = 32'h00000000; prog[11] = 32'h00000000;
      prog[12] = 32'h00000008;

      reset = 1'b1; load_en = 1'b0; load_index = '0; load_data = '0; start = 1'b0;
      expected_v0 = '0; instr_address = RV; active = 1'b1; register_v0 = 32'd128;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_fail", {31'd0, fail}, 32'd0);
      chk("rst_cycles", {16'd0, cycle_count}, 32'd0);
      chk("rst_v0", v0_captured, 32'd0);
      reset = 1'b0;

      load_prog();

      // Write and read of the same word on one edge: old word first, new word after the edge.
      load_word(20, 32'h11111111);
      @(negedge clk);
      instr_address = RV + 32'd80; load_en = 1'b1; load_index = AW'(20); load_data = 32'hA5A5A5A5;
      #1 chk("rw_same_old", instr_readdata, 32'h11111111);
      @(posedge clk);
      #1 chk("rw_same_new", instr_readdata, 32'hA5A5A5A5);
      load_en = 1'b0; instr_address = RV;

      // PASS run, with a load attempted mid-RUN.
      run_seq(32'd128, '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, v0: 32'd128}, 1'b1);
`ifdef MONITOR_ACTIVE_HALT_EN
      chk("hba_addr_halt", {31'd0, halt_by_active}, 32'd0);
`endif
      instr_address = RV + 32'd12;
      #1 chk("rom_kept_in_run", instr_readdata, prog[3]);
      instr_address = RV + 32'(4 * DEPTH);
      #1 chk("rom_past_end", instr_readdata, 32'h0);
      instr_address = RV + 32'd2;
      #1 chk("rom_unaligned", instr_readdata, 32'h0);
      instr_address = RV;

      // FAIL run.
      run_seq(32'd96, '{pass: 1'b0, fail: 1'b1, timeout: 1'b0, v0: 32'd128}, 1'b0);
      chk("fail_done", {31'd0, done}, 32'd1);

      // Branch-to-self loop: no halt, so v0_captured keeps the previous run's value.
      load_word(0, 32'h1000FFFF);
      load_word(1, 32'h00000000);
      start_run(32'd0, '{pass: 1'b0, fail: 1'b1, timeout: 1'b1, v0: 32'd128});
      w = 0;
      while (!done && w < TO + 10) begin
         instr_address = RV + 32'(4 * (w % 2));
         @(negedge clk);
         w++;
      end
      chk("to_edges", 32'(w), 32'(TO));
      chk("to_cycles", {16'd0, cycle_count}, 32'(TO));
      wait_done(1, w);
      instr_address = RV;

      // Asynchronous reset mid-RUN, then rerun the retained program.
      load_prog();
      start_run(32'd128, '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, v0: 32'd128});
      for (int k = 0; k < 4; k++) begin
         instr_address = RV + 32'(4 * k);
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_pass", {31'd0, pass}, 32'd0);
      chk("arst_fail", {31'd0, fail}, 32'd0);
      chk("arst_timeout", {31'd0, timeout}, 32'd0);
      chk("arst_cycles", {16'd0, cycle_count}, 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      run_seq(32'd128, '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, v0: 32'd128}, 1'b0);

`ifdef MONITOR_ACTIVE_HALT_EN
      // Halt by falling edge of active with no halt fetch.
      register_v0 = 32'd7;
      start_run(32'd7, '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, v0: 32'd7});
      for (int k = 0; k < 10; k++) begin
         instr_address = RV + 32'(4 * k);
         if (k == 9) active = 1'b0;
         @(negedge clk);
      end
      wait_done(10, w);
      chk("hba_set", {31'd0, halt_by_active}, 32'd1);
      active = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=expired want=finish");
      $fatal(1);
   end

endmodule

// File: doc/mips_harvard_test_monitor.md
Name: mips_harvard_test_monitor

Overview:
Parametrised program-driver and result checker for the Harvard MIPS CPU. It replaces the per-test hard-coded instruction decode with a loadable instruction ROM, and adds a run-control FSM. The FSM detects the halt fetch, checks register_v0 against an expected value, and flags timeouts. It sits beside mips_cpu_harvard in every directed CPU bench, such as the branch/jump, ALU and memory suites.

Parameters:
ROM_DEPTH, 64, number of 32-bit instruction words (power of two, 4..1024)
RESET_VECTOR, 32'hBFC00000, byte address of ROM word 0
HALT_ADDR, 32'h00000000, fetch address that signals program end
TIMEOUT_CYCLES, 256, RUN cycles allowed before TIMEOUT (1..65535)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
load_en  in  1  write load_data into ROM at load_index (IDLE or DONE only)
load_index  in  $clog2(ROM_DEPTH)  ROM word index for load
load_data  in  32  instruction word to load
start  in  1  one-cycle pulse, begin RUN
expected_v0  in  32  value register_v0 must hold at halt
instr_address  in  32  CPU fetch address
instr_readdata  out  32  instruction word to CPU
active  in  1  CPU active flag
register_v0  in  32  CPU $v0 debug output
busy  out  1  high in RUN and CHECK
done  out  1  high in PASS, FAIL, TIMEOUT
pass  out  1  high in PASS only
fail  out  1  high in FAIL or TIMEOUT
timeout  out  1  high in TIMEOUT only
cycle_count  out  16  RUN cycles elapsed, saturating at 16'hFFFF
v0_captured  out  32  register_v0 sampled at halt

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - cycle_count=0, v0_captured=0.
  - All flags 0.
  - ROM contents undefined. Benches must load before start; the RTL has no clearing loop.
- ROM read is combinational, zero latency (the CPU samples the fetch in the same cycle).
  - word = (instr_address - RESET_VECTOR) >> 2.
  - Unaligned address (bits[1:0]!=0) or word >= ROM_DEPTH: instr_readdata = 32'h00000000 (NOP).
- ROM write is synchronous on a rising edge with load_en=1.
  - Ignored in RUN and CHECK.
  - A write and a read of the same word in the same cycle returns the old word.
- FSM states: IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT.
- IDLE: start=1 -> RUN, and cycle_count cleared to 0.
- RUN:
  - cycle_count increments every cycle, saturating.
  - Halt fetch: instr_address==HALT_ADDR sampled on the edge -> CHECK. v0_captured loads register_v0 on that same edge.
  - Otherwise, cycle_count==TIMEOUT_CYCLES-1 on the edge -> TIMEOUT.
  - Halt and timeout on the same edge: halt wins.
  - start is ignored while in RUN.
- CHECK: one cycle, then v0_captured==expected_v0 -> PASS, else -> FAIL.
  - expected_v0 is sampled in CHECK, not at start.
- PASS / FAIL / TIMEOUT: sticky. start=1 -> RUN with cycle_count cleared; the ROM is kept.
- Flags are decoded from registered state, so they carry no combinational paths from inputs.
- active is informational only in the base block.
- Reset asserted mid-RUN: immediate IDLE, all flags low. ROM contents are retained but not guaranteed.

Optional Feature:
- Macro: MONITOR_ACTIVE_HALT_EN.
- Defined:
  - In RUN, a falling edge of active (registered previous 1, current 0) is a second halt condition with the same priority as the address halt.
  - v0_captured is loaded on that edge.
  - Extra output halt_by_active (1 bit) is set when that path triggered the halt. It is cleared on start or reset.
- Undefined: active is ignored, and the halt_by_active port does not exist.

Test Plan:
- Load the 13-word blez program from RESET_VECTOR (last word jr $0 -> fetch 0), expected_v0=128, start -> PASS within 40 cycles, v0_captured=128, fail=0.
- Same program, expected_v0=96 -> FAIL, v0_captured=128, pass=0, done=1.
- ROM holding only a branch-to-self loop (beq $0,$0,-1 plus NOP), TIMEOUT_CYCLES=50 -> TIMEOUT asserted when cycle_count reaches 49, fail=1, timeout=1.
- Fetch at RESET_VECTOR+4*ROM_DEPTH and at RESET_VECTOR+2 -> instr_readdata=0. load_en during RUN leaves the word unchanged, confirmed by readback after PASS.
- Reset pulsed asynchronously mid-RUN (between clock edges) -> busy=0 and all flags 0 before the next edge. A following start reruns the retained program to PASS.
- With MONITOR_ACTIVE_HALT_EN: active driven 1->0 at cycle 10 with no halt fetch, register_v0=7, expected_v0=7 -> PASS, halt_by_active=1.
